// File: rtl/bank_sched_pkg.sv
// Shared types and constants for the open-row-aware bank read scheduler.
package bank_sched_pkg;

  localparam int         ROW_W    = 4;
  localparam int         DATA_W   = 32;
  localparam logic [4:0] ROW_NONE = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/bank_read_scheduler_if.sv
// Requester, bank and response signals of the scheduler; slave is the scheduler side.
interface bank_read_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  import bank_sched_pkg::*;

  logic [N-1:0]       req_valid;
  logic [ROW_W*N-1:0] req_row;
  logic [N-1:0]       req_ready;

  logic               bank_in_valid;
  logic [ROW_W-1:0]   bank_row_num;
  logic               bank_out_valid;
  logic [DATA_W-1:0]  bank_data;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;
  logic [4:0]         open_row;

  modport slave (
    input  req_valid, req_row, bank_out_valid, bank_data, rsp_ready,
    output req_ready, bank_in_valid, bank_row_num, rsp_valid, rsp_id, rsp_data, rsp_err, open_row
  );

  modport master (
    output req_valid, req_row, bank_out_valid, bank_data, rsp_ready,
    input  req_ready, bank_in_valid, bank_row_num, rsp_valid, rsp_id, rsp_data, rsp_err, open_row
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask_i scanning upward from start_i with wrap.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   mask_i,
  input  logic [IDW-1:0] start_i,
  output logic [N-1:0]   onehot_o,
  output logic [IDW-1:0] idx_o
);

  logic           found;
  logic [IDW-1:0] pos;

  // NOTE: every output and temporary gets a default first so no path infers a latch.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDW'((int'(start_i) + k) % N);
      if (!found && mask_i[pos]) begin
        found         = 1'b1;
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
      end
    end
  end

endmodule

// File: rtl/bank_read_scheduler.sv
// Buffers one read per requester, grants row hits first (streak-capped) else rotating,
// keeps one bank read outstanding and returns the tagged result or a timeout error.
module bank_read_scheduler
  import bank_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int IDW        = 2,
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT    = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  bank_read_scheduler_if.slave bus
);

  localparam int              SW         = $clog2(MAX_STREAK + 1);
  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]   STREAK_CAP = SW'(MAX_STREAK);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  LAST_ID    = IDW'(N - 1);

  state_e            state_q;
  logic [N-1:0]      pend_q, pend_d;
  logic [ROW_W-1:0]  row_q [N];
  logic [IDW-1:0]    gnt_id_q, rr_ptr_q;
  logic [SW-1:0]     streak_q;
  logic [TW-1:0]     tmo_q;
  logic [4:0]        open_row_q;
  logic              bank_in_valid_q;
  logic [ROW_W-1:0]  bank_row_num_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [N-1:0]      accept, hit_set, hit_oh, pend_oh, gnt_oh;
  logic [IDW-1:0]    hit_idx, pend_idx, gnt_idx;
  logic              use_hit, do_grant;

  always_comb begin
    hit_set = '0;
    for (int i = 0; i < N; i++) begin
      hit_set[i] = pend_q[i] && ({1'b0, row_q[i]} == open_row_q);
    end
  end

  rr_pick #(.N(N), .IDW(IDW)) u_hit_pick (
    .mask_i   (hit_set),
    .start_i  (rr_ptr_q),
    .onehot_o (hit_oh),
    .idx_o    (hit_idx)
  );

  rr_pick #(.N(N), .IDW(IDW)) u_pend_pick (
    .mask_i   (pend_q),
    .start_i  (rr_ptr_q),
    .onehot_o (pend_oh),
    .idx_o    (pend_idx)
  );

  // Hits win until the streak cap, then one rotating grant breaks the run.
  assign use_hit  = (|hit_set) && (streak_q < STREAK_CAP);
  assign gnt_oh   = use_hit ? hit_oh  : pend_oh;
  assign gnt_idx  = use_hit ? hit_idx : pend_idx;
  assign do_grant = (state_q == IDLE) && (|pend_q);
  assign accept   = bus.req_valid & ~pend_q;
  assign pend_d   = (pend_q & ~({N{do_grant}} & gnt_oh)) | accept;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pend_q          <= '0;
      gnt_id_q        <= '0;
      rr_ptr_q        <= '0;
      streak_q        <= '0;
      tmo_q           <= '0;
      open_row_q      <= ROW_NONE;
      bank_in_valid_q <= 1'b0;
      bank_row_num_q  <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_id_q        <= '0;
      rsp_data_q      <= '0;
    end else begin
      pend_q          <= pend_d;
      bank_in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            bank_in_valid_q <= 1'b1;
            bank_row_num_q  <= row_q[gnt_idx];
            gnt_id_q        <= gnt_idx;
            open_row_q      <= {1'b0, row_q[gnt_idx]};
            rr_ptr_q        <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            streak_q        <= use_hit ? streak_q + 1'b1 : '0;
            tmo_q           <= '0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          if (bus.bank_out_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= gnt_id_q;
            rsp_data_q  <= bus.bank_data;
            state_q     <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            // The bank's row state is unknown after a lost read, so forget the mirror.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= gnt_id_q;
            rsp_data_q  <= '0;
            open_row_q  <= ROW_NONE;
            state_q     <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: row storage has no reset; an entry is only consumed while its pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i]) row_q[i] <= bus.req_row[ROW_W*i +: ROW_W];
    end
  end

  assign bus.req_ready     = ~pend_q;
  assign bus.bank_in_valid = bank_in_valid_q;
  assign bus.bank_row_num  = bank_row_num_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.open_row      = open_row_q;

endmodule

// File: tb/tb_bank_read_scheduler.sv
// Directed bench for bank_read_scheduler with an open-row bank model (hit 1, closed 2, conflict 3).
module tb_bank_read_scheduler;
  import bank_sched_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bank_read_scheduler_if #(.N(N), .IDW(IDW)) bif ();

  bank_read_scheduler #(
    .N(N), .IDW(IDW), .MAX_STREAK(3), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank model: its open row survives scheduler reset; a stall suppresses results.
  logic [4:0]       bank_open  = ROW_NONE;
  logic [ROW_W-1:0] bank_row   = '0;
  int               bank_cnt   = 0;
  logic             bank_stall = 1'b0;

  function automatic int bank_lat(input logic [4:0] open, input logic [ROW_W-1:0] row);
    if (open == {1'b0, row}) return 1;
    if (open == ROW_NONE) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    bif.bank_out_valid <= 1'b0;
    if (bif.bank_in_valid === 1'b1) begin
      bank_open <= {1'b0, bif.bank_row_num};
      bank_row  <= bif.bank_row_num;
      if (bank_lat(bank_open, bif.bank_row_num) == 1) begin
        bank_cnt <= 0;
        if (!bank_stall) begin
          bif.bank_out_valid <= 1'b1;
          bif.bank_data      <= {28'd0, bif.bank_row_num};
        end
      end else begin
        bank_cnt <= bank_lat(bank_open, bif.bank_row_num) - 1;
      end
    end else if (bank_cnt > 0) begin
      bank_cnt <= bank_cnt - 1;
      if (bank_cnt == 1 && !bank_stall) begin
        bif.bank_out_valid <= 1'b1;
        bif.bank_data      <= {28'd0, bank_row};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [ROW_W-1:0] row);
    bif.req_row[ROW_W*i +: ROW_W] = row;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (bif.bank_in_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_issue"}, 32'(bif.bank_in_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bif.req_ready), 32'hF);
    check({tag, "_bank_in_valid"}, 32'(bif.bank_in_valid), 32'd0);
    check({tag, "_bank_row_num"}, 32'(bif.bank_row_num), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(bif.rsp_id), 32'd0);
    check({tag, "_rsp_data"}, bif.rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(bif.rsp_err), 32'd0);
    check({tag, "_open_row"}, 32'(bif.open_row), 32'd16);
  endtask

  // One grant: issue, one-cycle strobe, issue-to-response ticks, tagged response.
  task automatic serve(input string tag, input int exp_id, input int exp_row, input int exp_ticks);
    int n;
    wait_issue(tag);
    check({tag, "_row"}, 32'(bif.bank_row_num), 32'(exp_row));
    check({tag, "_open_row"}, 32'(bif.open_row), 32'(exp_row));
    check({tag, "_ready"}, 32'(bif.req_ready[exp_id]), 32'd1);
    tick();
    n = 1;
    check({tag, "_pulse"}, 32'(bif.bank_in_valid), 32'd0);
    while (bif.rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_ticks));
    check({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(bif.rsp_id), 32'(exp_id));
    check({tag, "_rsp_data"}, bif.rsp_data, 32'(exp_row));
    check({tag, "_rsp_err"}, 32'(bif.rsp_err), 32'd0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bif.req_valid = '0;
    bif.req_row   = '0;
    bif.rsp_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Lone request to a closed bank.
    set_req(2, 4'd5);
    bif.req_valid = 4'b0100;
    tick();
    check("t1_enqueue", 32'(bif.req_ready), 32'hB);
    bif.req_valid = '0;
    serve("t1", 2, 5, 3);

    // Hit on row 5 beats the rotating pointer; then the conflict.
    set_req(0, 4'd9);
    set_req(3, 4'd5);
    bif.req_valid = 4'b1001;
    tick();
    check("t2_enqueue", 32'(bif.req_ready), 32'h6);
    bif.req_valid = '0;
    serve("t2_hit", 3, 5, 2);
    serve("t2_conf", 0, 9, 4);

    // Open row 7 with rr_ptr at 2, then a stream of row-7 hits against one row-3 request.
    set_req(1, 4'd7);
    bif.req_valid = 4'b0010;
    tick();
    bif.req_valid = '0;
    serve("t3_open", 1, 7, 4);
    set_req(0, 4'd7);
    set_req(1, 4'd3);
    set_req(2, 4'd7);
    set_req(3, 4'd7);
    bif.req_valid = 4'b1111;
    tick();
    bif.req_valid = 4'b1101;
    serve("t3_g1", 2, 7, 2);
    serve("t3_g2", 3, 7, 2);
    serve("t3_g3", 0, 7, 2);
    serve("t3_g4", 1, 3, 4);
    serve("t3_g5", 2, 7, 4);
    bif.req_valid = '0;
    serve("t3_g6", 3, 7, 2);
    serve("t3_g7", 0, 7, 2);
    serve("t3_g8", 2, 7, 2);

    // Held response: streak is at the cap, so req 0 wins by rotation; req 1 waits.
    set_req(0, 4'd7);
    set_req(1, 4'd4);
    bif.req_valid = 4'b0011;
    tick();
    bif.rsp_ready = 1'b0;
    bif.req_valid = '0;
    check("t4_enqueue", 32'(bif.req_ready), 32'hC);
    serve("t4_held", 0, 7, 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_valid", 32'(bif.rsp_valid), 32'd1);
      check("t4_hold_id", 32'(bif.rsp_id), 32'd0);
      check("t4_hold_data", bif.rsp_data, 32'd7);
      check("t4_hold_err", 32'(bif.rsp_err), 32'd0);
      check("t4_hold_no_issue", 32'(bif.bank_in_valid), 32'd0);
      check("t4_hold_ready", 32'(bif.req_ready), 32'hD);
    end
    bif.rsp_ready = 1'b1;
    tick();
    check("t4_accepted", 32'(bif.rsp_valid), 32'd0);
    serve("t4_next", 1, 4, 4);

    // Bank never answers: error response after 15 WAIT cycles.
    bank_stall = 1'b1;
    set_req(3, 4'd4);
    bif.req_valid = 4'b1000;
    tick();
    bif.req_valid = '0;
    wait_issue("t5");
    check("t5_row", 32'(bif.bank_row_num), 32'd4);
    n = 0;
    do begin
      tick();
      n++;
    end while (bif.rsp_valid !== 1'b1 && n < 40);
    check("t5_timeout_ticks", 32'(n), 32'd15);
    check("t5_rsp_valid", 32'(bif.rsp_valid), 32'd1);
    check("t5_rsp_err", 32'(bif.rsp_err), 32'd1);
    check("t5_rsp_data", bif.rsp_data, 32'd0);
    check("t5_rsp_id", 32'(bif.rsp_id), 32'd3);
    check("t5_open_row", 32'(bif.open_row), 32'd16);
    bank_stall = 1'b0;
    set_req(1, 4'd4);
    bif.req_valid = 4'b0010;
    tick();
    bif.req_valid = '0;
    serve("t5_resume", 1, 4, 2);

    // Reset during WAIT drops the read; the late bank result must be ignored.
    set_req(2, 4'd9);
    bif.req_valid = 4'b0100;
    tick();
    bif.req_valid = '0;
    wait_issue("t6");
    check("t6_row", 32'(bif.bank_row_num), 32'd9);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t6_no_rsp", 32'(bif.rsp_valid), 32'd0);
      check("t6_no_issue", 32'(bif.bank_in_valid), 32'd0);
    end
    set_req(0, 4'd9);
    bif.req_valid = 4'b0001;
    tick();
    bif.req_valid = '0;
    serve("t6_resume", 0, 9, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_read_scheduler.md
Name: bank_read_scheduler

Overview:
Shares one single-bank, open-row read model among N requesters. It buffers one request per requester and picks requests with an open-row-aware policy: row hits go first, subject to a streak cap, otherwise rotating priority. It issues one read at a time to the bank, waits for the bank's result and returns it tagged with the requester id. It sits between the requester ports and the bank read block.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(N)
MAX_STREAK, 3, maximum consecutive hit-priority grants before forced rotating-priority grant
TIMEOUT, 15, WAIT cycles without bank_out_valid before an error response

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  N  per-requester request strobe
req_row  in  4*N  row number; requester i uses bits [4i+3:4i]
req_ready  out  N  per-requester buffer empty
bank_in_valid  out  1  one-cycle issue strobe to the bank
bank_row_num  out  4  row number for the bank
bank_out_valid  in  1  bank result strobe
bank_data  in  32  bank result data
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester index of the response
rsp_data  out  32  read data (0 on error)
rsp_err  out  1  timeout flag
open_row  out  5  mirror of the bank open row; 16 means none open

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset values:
  - all pend bits 0, so req_ready = all 1s
  - bank_in_valid 0, bank_row_num 0
  - rsp_valid/rsp_id/rsp_data/rsp_err 0
  - open_row 16, rr_ptr 0, streak 0, state IDLE
- Request buffer: req_ready[i] = ~pend[i], registered. On req_valid[i] & req_ready[i], set pend[i] and capture row[i]. req_valid while not ready is ignored; the requester must hold it.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no pend: stay, bank_in_valid 0.
- IDLE, any pend: grant one requester (selection below), then on the same edge:
  - bank_in_valid <= 1 for exactly one cycle; bank_row_num <= row[w]
  - clear pend[w]; latch gnt_id <= w
  - open_row <= row[w]; rr_ptr <= (w+1) mod N
  - clear the timeout counter; go to WAIT
- Grant selection:
  - hit set H = pend & (row[i] == open_row)
  - if H is nonzero and streak < MAX_STREAK: w = first set bit of H scanning from rr_ptr upward with wrap; streak <= streak+1
  - otherwise: w = first set bit of pend scanning from rr_ptr; streak <= 0
- WAIT:
  - on bank_out_valid: rsp_data <= bank_data, rsp_id <= gnt_id, rsp_err <= 0, rsp_valid <= 1, go to RESP
  - else increment the counter; when it reaches TIMEOUT: rsp_err <= 1, rsp_data <= 0, rsp_valid <= 1, open_row <= 16, go to RESP
  - no issue while in WAIT; the bank restarts on a new strobe, so only one read is outstanding
- RESP: hold rsp_* stable while rsp_ready is 0. On rsp_ready, rsp_valid <= 0 and go to IDLE. The next grant comes no earlier than the following cycle.
- bank_out_valid outside WAIT is ignored, including stray results after a reset.
- Expected latency, issue edge to bank_out_valid: hit 1 cycle, row closed 2, row conflict 3. Response is visible one cycle after bank_out_valid.
- Reset mid-operation: any outstanding read is dropped with no response, and open_row returns to 16. The bank's row state is not reset; a stale open row affects timing only, never correctness.
- Simultaneous events:
  - enqueue on another requester during a grant cycle is accepted
  - the granted requester's req_ready rises the cycle after its grant

Decomposition:
- Package bank_sched_pkg:
  - state enum {IDLE, WAIT, RESP}
  - ROW_W=4, DATA_W=32, ROW_NONE=5'd16
- Sub-module rr_pick (mask in, start pointer in, one-hot and index out). It is instantiated twice: once for the hit set and once for the pend set.

Test Plan:
- Reset, then req 2 row 5 alone -> bank_row_num 5; closed-row latency; rsp_id 2, rsp_data 5, open_row 5.
- After open_row 5: req 0 row 9 and req 3 row 5 in the same cycle -> req 3 granted first (hit), then req 0. Hit response 1 cycle after issue, conflict 3.
- All 4 requesters row 7 continuously, with one row-3 request at req 1 -> row-3 request granted no later than grant MAX_STREAK+1, then streak 0.
- rsp_ready low for 5 cycles -> rsp_* stable, no bank_in_valid until accept; pending requests wait.
- bank_out_valid forced low -> after 15 WAIT cycles rsp_err 1, rsp_data 0, open_row 16, then normal service resumes.
- rst_n asserted in WAIT -> next cycle all outputs at reset values, late bank_out_valid ignored, no response.
